// File: rtl/master_link_router.sv
// Frame router: rx frames fan out to slaves as master_data/valid_bus; slaves polled round-robin for tx frames.
// Latency: payload strobe 1 cycle after rx_valid; tx header starts 1 cycle after select; payload 1 byte per 2 cycles.
// Backpressure: tx held under tx_valid until tx_ready; rx has none. Optional gap timeout via RX_TIMEOUT_EN.
module master_link_router #(
    parameter int         NUM_ADDR  = 21,
    parameter logic [7:0] SYNC_BYTE = 8'h55,
    parameter int         TIMEOUT   = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            master_data,
    output logic [NUM_ADDR-1:0]   valid_bus,
    input  logic [NUM_ADDR-1:0]   have_msg_bus,
    input  logic [NUM_ADDR*8-1:0] len_bus,
    input  logic [NUM_ADDR*8-1:0] slave_data_bus,
    output logic [NUM_ADDR-1:0]   rdreq_bus,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  err_addr,
    output logic                  err_timeout
);
    localparam int PW = $clog2(NUM_ADDR);

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_ADDR = 2'd1;
    localparam logic [1:0] RX_LEN  = 2'd2;
    localparam logic [1:0] RX_DATA = 2'd3;

    localparam logic [2:0] TX_IDLE     = 3'd0;
    localparam logic [2:0] TX_HDR_SYNC = 3'd1;
    localparam logic [2:0] TX_HDR_ADDR = 3'd2;
    localparam logic [2:0] TX_HDR_LEN  = 3'd3;
    localparam logic [2:0] TX_LOAD     = 3'd4;
    localparam logic [2:0] TX_SEND     = 3'd5;

    // ---------------- RX path ----------------
    logic [1:0]          rx_state;
    logic [7:0]          rx_addr;
    logic [7:0]          rx_cnt;
    logic                addr_ok;
    logic [NUM_ADDR-1:0] rx_onehot;

    assign addr_ok   = int'(rx_addr) < NUM_ADDR;
    assign rx_onehot = NUM_ADDR'(1'b1) << rx_addr;

`ifdef RX_TIMEOUT_EN
    logic [15:0] gap_cnt;
    logic        err_timeout_q;
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            rx_addr     <= 8'd0;
            rx_cnt      <= 8'd0;
            master_data <= 8'd0;
            valid_bus   <= '0;
            err_addr    <= 1'b0;
`ifdef RX_TIMEOUT_EN
            gap_cnt       <= 16'd0;
            err_timeout_q <= 1'b0;
`endif
        end else begin
            valid_bus <= '0;
            err_addr  <= 1'b0;
`ifdef RX_TIMEOUT_EN
            err_timeout_q <= 1'b0;
`endif
            if (rx_valid) begin
`ifdef RX_TIMEOUT_EN
                gap_cnt <= 16'd0;
`endif
                case (rx_state)
                    RX_IDLE: if (rx_data == SYNC_BYTE) rx_state <= RX_ADDR;
                    RX_ADDR: begin
                        rx_addr  <= rx_data;
                        rx_state <= RX_LEN;
                    end
                    RX_LEN: begin
                        err_addr <= !addr_ok;
                        rx_cnt   <= rx_data;
                        rx_state <= (rx_data == 8'd0) ? RX_IDLE : RX_DATA;
                    end
                    default: begin
                        // Out-of-range frames still consume their payload, just without strobes.
                        if (addr_ok) begin
                            master_data <= rx_data;
                            valid_bus   <= rx_onehot;
                        end
                        rx_cnt <= rx_cnt - 8'd1;
                        if (rx_cnt == 8'd1) rx_state <= RX_IDLE;
                    end
                endcase
            end
`ifdef RX_TIMEOUT_EN
            else if (rx_state != RX_IDLE) begin
                if (gap_cnt == 16'(TIMEOUT - 1)) begin
                    gap_cnt       <= 16'd0;
                    rx_state      <= RX_IDLE;
                    err_timeout_q <= 1'b1;
                end else begin
                    gap_cnt <= gap_cnt + 16'd1;
                end
            end else begin
                gap_cnt <= 16'd0;
            end
`endif
        end
    end

    // ---------------- TX path ----------------
    logic [2:0]          tx_state;
    logic [PW-1:0]       tx_sel;
    logic [PW-1:0]       rr_ptr;
    logic [7:0]          tx_len;
    logic [7:0]          tx_cnt;
    logic                scan_found;
    logic [PW-1:0]       scan_idx;
    logic [7:0]          scan_len;
    logic [PW-1:0]       rr_next;
    logic [NUM_ADDR-1:0] tx_onehot;
    logic [7:0]          slave_head;

    // Search starts at rr_ptr and wraps; slaves advertising zero length are passed over.
    always_comb begin
        int idx;
        idx        = 0;
        scan_found = 1'b0;
        scan_idx   = '0;
        scan_len   = 8'd0;
        for (int i = 0; i < NUM_ADDR; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_ADDR) idx = idx - NUM_ADDR;
            if (!scan_found && have_msg_bus[idx] && len_bus[idx*8 +: 8] != 8'd0) begin
                scan_found = 1'b1;
                scan_idx   = PW'(idx);
                scan_len   = len_bus[idx*8 +: 8];
            end
        end
    end

    assign rr_next    = (int'(scan_idx) == NUM_ADDR - 1) ? '0 : scan_idx + PW'(1);
    assign tx_onehot  = NUM_ADDR'(1'b1) << tx_sel;
    assign slave_head = slave_data_bus[int'(tx_sel)*8 +: 8];
    assign rdreq_bus  = (tx_state == TX_SEND && tx_ready) ? tx_onehot : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_sel   <= '0;
            rr_ptr   <= '0;
            tx_len   <= 8'd0;
            tx_cnt   <= 8'd0;
            tx_data  <= 8'd0;
            tx_valid <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: if (scan_found) begin
                    tx_sel   <= scan_idx;
                    tx_len   <= scan_len;
                    tx_cnt   <= scan_len;
                    rr_ptr   <= rr_next;
                    tx_data  <= SYNC_BYTE;
                    tx_valid <= 1'b1;
                    tx_state <= TX_HDR_SYNC;
                end
                TX_HDR_SYNC: if (tx_ready) begin
                    tx_data  <= 8'(tx_sel);
                    tx_state <= TX_HDR_ADDR;
                end
                TX_HDR_ADDR: if (tx_ready) begin
                    tx_data  <= tx_len;
                    tx_state <= TX_HDR_LEN;
                end
                TX_HDR_LEN: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    tx_state <= TX_LOAD;
                end
                // One dead cycle lets the slave's show-ahead head settle after the previous pop.
                TX_LOAD: begin
                    tx_data  <= slave_head;
                    tx_valid <= 1'b1;
                    tx_state <= TX_SEND;
                end
                TX_SEND: if (tx_ready) begin
                    tx_valid <= 1'b0;
                    tx_cnt   <= tx_cnt - 8'd1;
                    tx_state <= (tx_cnt == 8'd1) ? TX_IDLE : TX_LOAD;
                end
                default: begin
                    tx_valid <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_master_link_router.sv
// Directed bench for master_link_router: rx fan-out, address errors, resets, tx polling/backpressure.
// Slaves are modelled as small show-ahead FIFOs; RX_TIMEOUT_EN selects the gap-timeout expectations.
module tb_master_link_router;
    localparam int NA = 21;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      rx_data;
    logic            rx_valid;
    logic [7:0]      master_data;
    logic [NA-1:0]   valid_bus;
    logic [NA-1:0]   have_msg_bus;
    logic [NA*8-1:0] len_bus;
    logic [NA*8-1:0] slave_data_bus;
    logic [NA-1:0]   rdreq_bus;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic            err_addr;
    logic            err_timeout;

    master_link_router dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .master_data(master_data), .valid_bus(valid_bus),
        .have_msg_bus(have_msg_bus), .len_bus(len_bus), .slave_data_bus(slave_data_bus),
        .rdreq_bus(rdreq_bus), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .err_addr(err_addr), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Slave model: message bytes in mem, length set by stimulus, pops counted by monitor.
    logic [7:0] mem [NA][4];
    int         msg_len [NA];
    logic [NA-1:0] have_force;
    int         pop_cnt [NA];

    always_comb begin
        have_msg_bus   = '0;
        len_bus        = '0;
        slave_data_bus = '0;
        for (int a = 0; a < NA; a++) begin
            have_msg_bus[a]          = (msg_len[a] != pop_cnt[a]) | have_force[a];
            len_bus[a*8 +: 8]        = 8'(msg_len[a] - pop_cnt[a]);
            slave_data_bus[a*8 +: 8] = mem[a][pop_cnt[a][1:0]];
        end
    end

    logic [28:0] rxq[$];
    logic [7:0]  txq[$];
    int err_addr_cnt = 0;
    int stall_viol   = 0;
    int rdreq_viol   = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;

    initial for (int a = 0; a < NA; a++) pop_cnt[a] = 0;

    always @(posedge clk) begin
        if (valid_bus != '0) rxq.push_back({valid_bus, master_data});
        if (err_addr) err_addr_cnt <= err_addr_cnt + 1;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
        if (prev_stall && (!tx_valid || tx_data != prev_data)) stall_viol <= stall_viol + 1;
        prev_stall <= tx_valid && !tx_ready;
        prev_data  <= tx_data;
        if ($countones(rdreq_bus) > 1 || (rdreq_bus != '0 && !(tx_valid && tx_ready)))
            rdreq_viol <= rdreq_viol + 1;
        for (int a = 0; a < NA; a++)
            if (rdreq_bus[a]) pop_cnt[a] <= pop_cnt[a] + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    int base;
    int ebase;
    int seen;
    logic [7:0] exp_tx [10];
    logic [7:0] exp_tx2 [6];

    initial begin
        rst = 1'b1; rx_data = 8'd0; rx_valid = 1'b0; tx_ready = 1'b0; have_force = '0;
        for (int a = 0; a < NA; a++) begin
            msg_len[a] = 0;
            for (int k = 0; k < 4; k++) mem[a][k] = 8'd0;
        end
        idle(3);
        check("rst_master_data", 32'(master_data), 32'h0);
        check("rst_valid_bus", 32'(valid_bus), 32'h0);
        check("rst_rdreq", 32'(rdreq_bus), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_err_addr", 32'(err_addr), 32'h0);
        check("rst_err_timeout", 32'(err_timeout), 32'h0);
        rst = 1'b0;
        idle(2);

        // Single-byte frame to address 11.
        base = rxq.size();
        send_byte(8'h55); send_byte(8'h0B); send_byte(8'h01); send_byte(8'h07);
        check("t1_valid_bus", 32'(valid_bus), 32'h000800);
        check("t1_master_data", 32'(master_data), 32'h07);
        idle(1);
        check("t1_valid_clear", 32'(valid_bus), 32'h0);
        idle(2);
        check("t1_strobe_cnt", 32'(rxq.size() - base), 32'd1);

        // Leading garbage ignored, three payload strobes to address 12.
        base = rxq.size();
        send_byte(8'h33); send_byte(8'h55); send_byte(8'h0C); send_byte(8'h03);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        idle(2);
        check("t2_strobe_cnt", 32'(rxq.size() - base), 32'd3);
        for (int i = 0; i < 3; i++)
            if (rxq.size() > base + i)
                check("t2_strobe", 32'(rxq[base+i]), {3'b0, 21'h001000, 8'(i + 1)});

        // Address 31 is out of range.
        base = rxq.size(); ebase = err_addr_cnt;
        send_byte(8'h55); send_byte(8'h1F); send_byte(8'h02);
        check("t3_err_addr_pulse", 32'(err_addr), 32'h1);
        idle(1);
        check("t3_err_addr_clear", 32'(err_addr), 32'h0);
        send_byte(8'hAA); send_byte(8'hBB);
        idle(2);
        check("t3_no_strobe", 32'(rxq.size() - base), 32'd0);
        check("t3_err_cnt", 32'(err_addr_cnt - ebase), 32'd1);

        // Edge addresses 0 and 20, then a zero-length frame followed by a normal one.
        base = rxq.size();
        send_byte(8'h55); send_byte(8'h00); send_byte(8'h01); send_byte(8'h5A);
        send_byte(8'h55); send_byte(8'h14); send_byte(8'h01); send_byte(8'hC3);
        send_byte(8'h55); send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h55); send_byte(8'h03); send_byte(8'h01); send_byte(8'h11);
        idle(2);
        check("t4_strobe_cnt", 32'(rxq.size() - base), 32'd3);
        if (rxq.size() >= base + 3) begin
            check("t4_addr0", 32'(rxq[base]), {3'b0, 21'h000001, 8'h5A});
            check("t4_addr20", 32'(rxq[base+1]), {3'b0, 21'h100000, 8'hC3});
            check("t4_after_len0", 32'(rxq[base+2]), {3'b0, 21'h000008, 8'h11});
        end

        // Reset mid-frame drops the rest of the frame.
        base = rxq.size();
        send_byte(8'h55); send_byte(8'h0B); send_byte(8'h03); send_byte(8'h01);
        @(negedge clk); rst = 1'b1;
        #1;
        check("t5_rst_valid_bus", 32'(valid_bus), 32'h0);
        check("t5_rst_master_data", 32'(master_data), 32'h0);
        idle(1); rst = 1'b0;
        send_byte(8'h02); send_byte(8'h03);
        idle(2);
        check("t5_strobe_cnt", 32'(rxq.size() - base), 32'd1);

        // TX: slaves 13 and 20 with two bytes each, link always ready.
        mem[13][0] = 8'hD0; mem[13][1] = 8'hD1;
        mem[20][0] = 8'hE0; mem[20][1] = 8'hE1;
        exp_tx = '{8'h55, 8'h0D, 8'h02, 8'hD0, 8'hD1, 8'h55, 8'h14, 8'h02, 8'hE0, 8'hE1};
        base = txq.size();
        @(negedge clk);
        tx_ready = 1'b1; msg_len[13] = 2; msg_len[20] = 2;
        for (int c = 0; c < 200 && txq.size() < base + 10; c++) @(negedge clk);
        idle(10);
        check("t6_tx_cnt", 32'(txq.size() - base), 32'd10);
        for (int i = 0; i < 10; i++)
            if (txq.size() > base + i) check("t6_tx_byte", 32'(txq[base+i]), 32'(exp_tx[i]));
        check("t6_pop13", 32'(pop_cnt[13]), 32'd2);
        check("t6_pop20", 32'(pop_cnt[20]), 32'd2);

        // TX under random backpressure; slave 2 advertises a message of length 0 and is skipped.
        mem[5][0] = 8'hA0; mem[5][1] = 8'hA1; mem[5][2] = 8'hA2;
        exp_tx2 = '{8'h55, 8'h05, 8'h03, 8'hA0, 8'hA1, 8'hA2};
        base = txq.size();
        @(negedge clk);
        have_force[2] = 1'b1; msg_len[5] = 3;
        for (int c = 0; c < 600 && txq.size() < base + 6; c++) begin
            @(negedge clk);
            tx_ready = 1'($urandom_range(0, 1));
        end
        tx_ready = 1'b1;
        idle(10);
        check("t7_tx_cnt", 32'(txq.size() - base), 32'd6);
        for (int i = 0; i < 6; i++)
            if (txq.size() > base + i) check("t7_tx_byte", 32'(txq[base+i]), 32'(exp_tx2[i]));
        check("t7_pop5", 32'(pop_cnt[5]), 32'd3);
        check("t7_pop2", 32'(pop_cnt[2]), 32'd0);
        check("t7_stall_stable", 32'(stall_viol), 32'd0);
        check("t7_rdreq_onehot", 32'(rdreq_viol), 32'd0);
        have_force[2] = 1'b0;

        // Long gap inside a frame.
        base = rxq.size();
        seen = 0;
        send_byte(8'h55); send_byte(8'h0B);
        for (int c = 0; c < 1010; c++) begin
            @(negedge clk);
            if (err_timeout) seen++;
        end
`ifdef RX_TIMEOUT_EN
        check("t8_timeout_pulse", 32'(seen), 32'd1);
        send_byte(8'h55); send_byte(8'h0B);
`else
        check("t8_no_timeout", 32'(seen), 32'd0);
`endif
        send_byte(8'h01); send_byte(8'h09);
        idle(2);
        check("t8_strobe_cnt", 32'(rxq.size() - base), 32'd1);
        if (rxq.size() > base) check("t8_strobe", 32'(rxq[base]), {3'b0, 21'h000800, 8'h09});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
